// File: rtl/cdc_pulse_scheduler.sv
// Round-robin scheduler that shares one forward/return CdcPulse channel pair
// between NUM_REQ requesters, with ack timeout and a post-transaction holdoff.
module cdc_pulse_scheduler #(
    parameter  int NUM_REQ        = 4,
    localparam int TAG_W          = $clog2(NUM_REQ),
    parameter  int HOLDOFF_CYCLES = 8,
    parameter  int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] pending,
    output logic               busy,
    output logic [TAG_W-1:0]   tx_tag,
    output logic               tx_pulse,
    input  logic               ack_pulse,
    output logic [NUM_REQ-1:0] done,
    output logic               timeout,
    output logic               stray_ack
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, HOLDOFF} state_t;

    state_t              state_reg, state_next;
    logic [NUM_REQ-1:0]  pending_reg, pending_next;
    logic [TAG_W-1:0]    tx_tag_reg, tx_tag_next;
    logic [TAG_W-1:0]    rr_start_reg, rr_start_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic                busy_reg, busy_next;
    logic                tx_pulse_reg, tx_pulse_next;
    logic [NUM_REQ-1:0]  done_reg, done_next;
    logic                timeout_reg, timeout_next;
    logic                stray_reg, stray_next;

    logic                found;
    logic [TAG_W-1:0]    win;
    logic [TAG_W:0]      arb_sum;
    logic [TAG_W-1:0]    arb_idx;
    logic [NUM_REQ-1:0]  grant_mask;
    logic [NUM_REQ-1:0]  tag_onehot;

    // Rotating-priority search: rr_start_reg holds the highest-priority index.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        arb_sum = '0;
        arb_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_sum = {1'b0, rr_start_reg} + (TAG_W+1)'(k);
            if (arb_sum >= (TAG_W+1)'(NUM_REQ))
                arb_sum = arb_sum - (TAG_W+1)'(NUM_REQ);
            arb_idx = arb_sum[TAG_W-1:0];
            if (!found && pending_reg[arb_idx]) begin
                found = 1'b1;
                win   = arb_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant_mask[gi] = found && (win == TAG_W'(gi));
            assign tag_onehot[gi] = (tx_tag_reg == TAG_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg | req;
        tx_tag_next   = tx_tag_reg;
        rr_start_next = rr_start_reg;
        wait_cnt_next = wait_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        tx_pulse_next = 1'b0;
        done_next     = '0;
        timeout_next  = 1'b0;
        stray_next    = ack_pulse && (state_reg != WAIT_ACK);

        case (state_reg)
            IDLE: begin
                if (enable && found) begin
                    tx_tag_next   = win;
                    // A request arriving in the grant cycle survives the clear.
                    pending_next  = (pending_reg & ~grant_mask) | req;
                    rr_start_next = (win == TAG_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                tx_pulse_next = 1'b1;
                wait_cnt_next = '0;
                state_next    = WAIT_ACK;
            end
            WAIT_ACK: begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
                if (ack_pulse) begin
                    done_next     = tag_onehot;
                    hold_cnt_next = '0;
                    state_next    = HOLDOFF;
                end else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES-1)) begin
                    timeout_next  = 1'b1;
                    hold_cnt_next = '0;
                    state_next    = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (hold_cnt_reg == HOLD_W'(HOLDOFF_CYCLES-1))
                    state_next = IDLE;
                else
                    hold_cnt_next = hold_cnt_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            tx_tag_reg   <= '0;
            rr_start_reg <= '0;
            wait_cnt_reg <= '0;
            hold_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            tx_pulse_reg <= 1'b0;
            done_reg     <= '0;
            timeout_reg  <= 1'b0;
            stray_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            tx_tag_reg   <= tx_tag_next;
            rr_start_reg <= rr_start_next;
            wait_cnt_reg <= wait_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            busy_reg     <= busy_next;
            tx_pulse_reg <= tx_pulse_next;
            done_reg     <= done_next;
            timeout_reg  <= timeout_next;
            stray_reg    <= stray_next;
        end
    end

    assign pending   = pending_reg;
    assign busy      = busy_reg;
    assign tx_tag    = tx_tag_reg;
    assign tx_pulse  = tx_pulse_reg;
    assign done      = done_reg;
    assign timeout   = timeout_reg;
    assign stray_ack = stray_reg;

endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// Directed bench for cdc_pulse_scheduler: a cycle table for the single-request
// flow plus hand-written round-robin, timeout, collision, enable and reset runs.
module tb_cdc_pulse_scheduler;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [3:0] pending;
    logic       busy;
    logic [1:0] tx_tag;
    logic       tx_pulse;
    logic       ack_pulse;
    logic [3:0] done;
    logic       timeout;
    logic       stray_ack;

    int cyc;
    int checks;
    int errors;

    cdc_pulse_scheduler #(
        .NUM_REQ(4),
        .HOLDOFF_CYCLES(8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .req(req),
        .pending(pending),
        .busy(busy),
        .tx_tag(tx_tag),
        .tx_pulse(tx_pulse),
        .ack_pulse(ack_pulse),
        .done(done),
        .timeout(timeout),
        .stray_ack(stray_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    typedef struct {
        int         n;
        logic [3:0] req;
        logic       ack;
        logic [3:0] pend;
        logic       busy;
        logic [1:0] tag;
        logic       txp;
        logic [3:0] done;
        logic       to;
        logic       stray;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_txp(output int t);
        int n;
        n = 0;
        while (tx_pulse !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("wait_tx_pulse", {31'd0, tx_pulse}, 32'd1);
        t = cyc;
        $display("txn: tx_pulse tag=%0d cycle=%0d", tx_tag, cyc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pending"}, {28'd0, pending}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_tag"}, {30'd0, tx_tag}, 32'd0);
        chk({name, "_txp"}, {31'd0, tx_pulse}, 32'd0);
        chk({name, "_done"}, {28'd0, done}, 32'd0);
        chk({name, "_timeout"}, {31'd0, timeout}, 32'd0);
        chk({name, "_stray"}, {31'd0, stray_ack}, 32'd0);
    endtask

    initial begin
        int t;
        int prev;
        int s;
        cyc = 0;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        enable = 1'b1;
        req = 4'b0000;
        ack_pulse = 1'b0;

        // single request flow: columns are n, req, ack | pending, busy, tag, tx_pulse, done, timeout, stray
        tbl[0]  = '{1, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{9, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0100, 1'b0, 1'b0};
        tbl[7]  = '{7, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[10] = '{1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[11] = '{2, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};

        // reset state
        tick(); tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // round robin from a fresh pointer
        req = 4'b1111;
        tick();
        req = 4'b0000;
        chk("rr_pending_set", {28'd0, pending}, 32'hF);
        chk("rr_busy_before_grant", {31'd0, busy}, 32'd0);
        tick();
        chk("rr_pending_after_grant", {28'd0, pending}, 32'hE);
        chk("rr_first_tag", {30'd0, tx_tag}, 32'd0);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_txp(t);
            chk("rr_tag", {30'd0, tx_tag}, k);
            if (k > 0) chk("rr_spacing", t - prev, 32'd16);
            prev = t;
            go(t + 5);
            ack_pulse = 1'b1;
            tick();
            ack_pulse = 1'b0;
            chk("rr_done", {28'd0, done}, 32'd1 << k);
        end
        wait_idle();
        chk("rr_pending_empty", {28'd0, pending}, 32'd0);

        // table-driven single request with a stray ack in IDLE
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                chk($sformatf("tbl%0d_pending", i), {28'd0, pending}, {28'd0, tbl[i].pend});
                chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
                chk($sformatf("tbl%0d_tag", i), {30'd0, tx_tag}, {30'd0, tbl[i].tag});
                chk($sformatf("tbl%0d_txp", i), {31'd0, tx_pulse}, {31'd0, tbl[i].txp});
                chk($sformatf("tbl%0d_done", i), {28'd0, done}, {28'd0, tbl[i].done});
                chk($sformatf("tbl%0d_timeout", i), {31'd0, timeout}, {31'd0, tbl[i].to});
                chk($sformatf("tbl%0d_stray", i), {31'd0, stray_ack}, {31'd0, tbl[i].stray});
                req       = (j == 0) ? tbl[i].req : 4'b0000;
                ack_pulse = (j == 0) ? tbl[i].ack : 1'b0;
                tick();
            end
        end
        req = 4'b0000;
        ack_pulse = 1'b0;

        // timeout on requester 1, req[3] queued meanwhile, stray ack in HOLDOFF
        req = 4'b0010;
        tick();
        req = 4'b0000;
        wait_txp(t);
        chk("to_tag", {30'd0, tx_tag}, 32'd1);
        for (int i = 1; i < 64; i++) begin
            tick();
            req = (i == 10) ? 4'b1000 : 4'b0000;
            chk("to_no_timeout_yet", {31'd0, timeout}, 32'd0);
            chk("to_no_done", {28'd0, done}, 32'd0);
        end
        req = 4'b0000;
        tick();
        chk("to_timeout_pulse", {31'd0, timeout}, 32'd1);
        chk("to_timeout_tag", {30'd0, tx_tag}, 32'd1);
        chk("to_timeout_done", {28'd0, done}, 32'd0);
        tick();
        chk("to_timeout_single", {31'd0, timeout}, 32'd0);
        go(t + 72);
        chk("to_holdoff_tag", {30'd0, tx_tag}, 32'd1);
        chk("to_queued_pending", {28'd0, pending}, 32'h8);
        go(t + 73);
        chk("to_next_grant_tag", {30'd0, tx_tag}, 32'd3);
        chk("to_next_grant_pending", {28'd0, pending}, 32'd0);
        go(t + 74);
        chk("to_next_txp", {31'd0, tx_pulse}, 32'd1);
        go(t + 76);
        ack_pulse = 1'b1;
        tick();
        ack_pulse = 1'b0;
        chk("to_next_done", {28'd0, done}, 32'h8);
        go(t + 79);
        ack_pulse = 1'b1;
        tick();
        ack_pulse = 1'b0;
        chk("hold_stray", {31'd0, stray_ack}, 32'd1);
        chk("hold_stray_no_done", {28'd0, done}, 32'd0);
        chk("hold_stray_busy", {31'd0, busy}, 32'd1);
        go(t + 84);
        chk("hold_still_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("hold_released", {31'd0, busy}, 32'd0);

        // req[0] repeated in its grant cycle; ack on the last timeout cycle
        req = 4'b0001;
        tick();
        chk("regrant_pending", {28'd0, pending}, 32'h1);
        tick();
        req = 4'b0000;
        chk("regrant_kept", {28'd0, pending}, 32'h1);
        chk("regrant_tag", {30'd0, tx_tag}, 32'd0);
        wait_txp(t);
        go(t + 63);
        ack_pulse = 1'b1;
        tick();
        ack_pulse = 1'b0;
        chk("collide_done", {28'd0, done}, 32'h1);
        chk("collide_no_timeout", {31'd0, timeout}, 32'd0);
        tick();
        chk("collide_no_late_timeout", {31'd0, timeout}, 32'd0);
        go(t + 73);
        chk("regrant_second_tag", {30'd0, tx_tag}, 32'd0);
        chk("regrant_cleared", {28'd0, pending}, 32'd0);
        go(t + 74);
        chk("regrant_second_txp", {31'd0, tx_pulse}, 32'd1);
        go(t + 79);
        ack_pulse = 1'b1;
        tick();
        ack_pulse = 1'b0;
        chk("regrant_second_done", {28'd0, done}, 32'h1);
        wait_idle();

        // enable gating
        enable = 1'b0;
        s = cyc;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        go(s + 6);
        chk("en_held_pending", {28'd0, pending}, 32'h2);
        chk("en_held_idle", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        tick();
        chk("en_grant_busy", {31'd0, busy}, 32'd1);
        chk("en_grant_tag", {30'd0, tx_tag}, 32'd1);
        enable = 1'b0;
        tick();
        chk("en_off_txp", {31'd0, tx_pulse}, 32'd1);
        ack_pulse = 1'b1;
        tick();
        ack_pulse = 1'b0;
        chk("en_off_done", {28'd0, done}, 32'h2);
        wait_idle();
        enable = 1'b1;

        // asynchronous reset in WAIT_ACK with pending=1010
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b1010;
        tick();
        req = 4'b0000;
        tick();
        chk("rst_pre_pending", {28'd0, pending}, 32'hA);
        chk("rst_pre_tag", {30'd0, tx_tag}, 32'd2);
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("rst_async");
        tick();
        chk_all_zero("rst_held");
        reset = 1'b0;
        req = 4'b1000;
        tick();
        req = 4'b0000;
        chk("rst_after_pending", {28'd0, pending}, 32'h8);
        tick();
        chk("rst_after_tag", {30'd0, tx_tag}, 32'd3);
        tick();
        chk("rst_after_txp", {31'd0, tx_pulse}, 32'd1);
        ack_pulse = 1'b1;
        tick();
        ack_pulse = 1'b0;
        chk("rst_after_done", {28'd0, done}, 32'h8);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
